// File: rtl/arb_pkg.sv
// Shared types and constants for the cpu_riscv memory-port arbiter.
// Encodes FSM states, grant ids and the line-size-derived widths.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IC_FILL = 2'd1,
        ARB_DC_ACC  = 2'd2
    } arb_state_e;

    localparam logic GNT_IC = 1'b0;
    localparam logic GNT_DC = 1'b1;

    localparam int unsigned LINE_WORDS_DEF = 4;

    // Beat counter is kept at least one bit wide so a one-word line still elaborates.
    function automatic int unsigned beat_width(input int unsigned line_words);
        return (line_words > 1) ? unsigned'($clog2(line_words)) : 1;
    endfunction

    function automatic int unsigned offset_bits(input int unsigned line_words);
        return unsigned'($clog2(4 * line_words));
    endfunction

    localparam int unsigned BEAT_W   = beat_width(LINE_WORDS_DEF);
    localparam int unsigned OFF_BITS = offset_bits(LINE_WORDS_DEF);

endpackage

// File: rtl/arb_grant_sel.sv
// Grant selection between the I-side and D-side requesters.
// ARB_ROUND_ROBIN_EN: alternate on contention; otherwise D-side has fixed priority.
module arb_grant_sel
    import arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic en_i,
    input  logic ic_req_i,
    input  logic dc_req_i,
    output logic valid_o,
    output logic id_o
);

    assign valid_o = en_i && (ic_req_i || dc_req_i);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;

    always_comb begin
        id_o = GNT_IC;
        if (ic_req_i && dc_req_i) begin
            id_o = (last_q == GNT_IC) ? GNT_DC : GNT_IC;
        end else if (dc_req_i) begin
            id_o = GNT_DC;
        end
    end

    // Reset to I-side so the first contention goes to the D-side.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GNT_IC;
        end else if (valid_o) begin
            last_q <= id_o;
        end
    end
`else
    assign id_o = dc_req_i ? GNT_DC : GNT_IC;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-wide memory port between I-cache line refills and D-side accesses.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin instead of D-side priority.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ic_read_i,
    input  logic [ADDR_W-1:0]        ic_addr_i,
    output logic [32*LINE_WORDS-1:0] ic_data_o,
    output logic                     ic_done_o,
    input  logic                     dc_ce_i,
    input  logic                     dc_we_i,
    input  logic [ADDR_W-1:0]        dc_addr_i,
    input  logic [3:0]               dc_sel_i,
    input  logic [31:0]              dc_data_i,
    output logic [31:0]              dc_data_o,
    output logic                     dc_done_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [3:0]               mem_sel_o,
    output logic [31:0]              mem_data_o,
    input  logic [31:0]              mem_data_i,
    input  logic                     mem_ack_i
);

    localparam int unsigned BeatW   = beat_width(LINE_WORDS);
    localparam int unsigned OffBits = offset_bits(LINE_WORDS);
    localparam int unsigned LineW   = 32 * LINE_WORDS;

    arb_state_e state_q, state_d;

    logic [BeatW-1:0]  beat_q;
    logic [BeatW-1:0]  beat_nxt;
    logic [ADDR_W-1:0] line_base_q;
    logic [LineW-1:0]  ic_data_q;
    logic [31:0]       dc_data_q;
    logic              ic_done_q;
    logic              dc_done_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_sel_q;
    logic [31:0]       mem_wdata_q;

    logic gnt_valid;
    logic gnt_id;
    logic beat_ack;
    logic last_beat;

    assign beat_ack  = mem_req_q && mem_ack_i;
    assign beat_nxt  = beat_q + 1'b1;
    assign last_beat = (beat_q == BeatW'(LINE_WORDS - 1));

    // A requester still holds its request during its own done cycle; mask it to avoid a re-grant.
    arb_grant_sel u_grant_sel (
`ifdef ARB_ROUND_ROBIN_EN
        .clk      (clk),
        .rst      (rst),
`endif
        .en_i     (state_q == ARB_IDLE),
        .ic_req_i (ic_read_i && !ic_done_q),
        .dc_req_i (dc_ce_i && !dc_done_q),
        .valid_o  (gnt_valid),
        .id_o     (gnt_id)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    state_d = (gnt_id == GNT_DC) ? ARB_DC_ACC : ARB_IC_FILL;
                end
            end
            ARB_IC_FILL: begin
                if (beat_ack && last_beat) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_DC_ACC: begin
                if (beat_ack) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q      <= '0;
            line_base_q <= '0;
            ic_data_q   <= '0;
            dc_data_q   <= '0;
            ic_done_q   <= 1'b0;
            dc_done_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_sel_q   <= '0;
            mem_wdata_q <= '0;
        end else begin
            ic_done_q <= 1'b0;
            dc_done_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (gnt_valid && (gnt_id == GNT_DC)) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dc_we_i;
                        mem_addr_q  <= dc_addr_i;
                        mem_sel_q   <= dc_sel_i;
                        mem_wdata_q <= dc_data_i;
                    end else if (gnt_valid) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_sel_q   <= 4'hF;
                        mem_addr_q  <= {ic_addr_i[ADDR_W-1:OffBits], {OffBits{1'b0}}};
                        line_base_q <= {ic_addr_i[ADDR_W-1:OffBits], {OffBits{1'b0}}};
                        beat_q      <= '0;
                    end
                end
                ARB_IC_FILL: begin
                    if (beat_ack) begin
                        ic_data_q[32*int'(beat_q) +: 32] <= mem_data_i;
                        if (last_beat) begin
                            beat_q    <= '0;
                            mem_req_q <= 1'b0;
                            ic_done_q <= 1'b1;
                        end else begin
                            beat_q     <= beat_nxt;
                            mem_addr_q <= line_base_q | (ADDR_W'(beat_nxt) << 2);
                        end
                    end
                end
                ARB_DC_ACC: begin
                    if (beat_ack) begin
                        if (!mem_we_q) begin
                            dc_data_q <= mem_data_i;
                        end
                        mem_req_q <= 1'b0;
                        dc_done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ic_data_o  = ic_data_q;
    assign ic_done_o  = ic_done_q;
    assign dc_data_o  = dc_data_q;
    assign dc_done_o  = dc_done_q;
    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_sel_o  = mem_sel_q;
    assign mem_data_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default fixed-priority build).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ic_read_i = 1'b0;
    logic [31:0]  ic_addr_i = '0;
    logic [127:0] ic_data_o;
    logic         ic_done_o;
    logic         dc_ce_i = 1'b0;
    logic         dc_we_i = 1'b0;
    logic [31:0]  dc_addr_i = '0;
    logic [3:0]   dc_sel_i = '0;
    logic [31:0]  dc_data_i = '0;
    logic [31:0]  dc_data_o;
    logic         dc_done_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [3:0]   mem_sel_o;
    logic [31:0]  mem_data_o;
    logic [31:0]  mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .LINE_WORDS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ic_read_i  (ic_read_i),
        .ic_addr_i  (ic_addr_i),
        .ic_data_o  (ic_data_o),
        .ic_done_o  (ic_done_o),
        .dc_ce_i    (dc_ce_i),
        .dc_we_i    (dc_we_i),
        .dc_addr_i  (dc_addr_i),
        .dc_sel_i   (dc_sel_i),
        .dc_data_i  (dc_data_i),
        .dc_data_o  (dc_data_o),
        .dc_done_o  (dc_done_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_sel_o  (mem_sel_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        if (mem_req_o !== 1'b0) begin
            $display("FAIL rst_mem_req: got %b want 0", mem_req_o);
        end else n_pass++;
        n_total++;
        if (mem_addr_o !== 32'h0) begin
            $display("FAIL rst_mem_addr: got %h want 0", mem_addr_o);
        end else n_pass++;
        n_total++;
        if ({mem_we_o, mem_sel_o, mem_data_o} !== 37'h0) begin
            $display("FAIL rst_mem_fields: got %h want 0", {mem_we_o, mem_sel_o, mem_data_o});
        end else n_pass++;
        n_total++;
        if (ic_data_o !== 128'h0) begin
            $display("FAIL rst_ic_data: got %h want 0", ic_data_o);
        end else n_pass++;
        n_total++;
        if ({dc_data_o, ic_done_o, dc_done_o} !== 34'h0) begin
            $display("FAIL rst_dc_done: got %h want 0", {dc_data_o, ic_done_o, dc_done_o});
        end else n_pass++;
        n_total++;
        rst = 1'b0;
        tick();
        if (mem_req_o !== 1'b0) begin
            $display("FAIL idle_no_req: got %b want 0", mem_req_o);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_dc_load();
        // Cycle 1: request; ack already high but ignored while mem_req_o is low.
        dc_ce_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 32'h100; dc_sel_i = 4'b1010;
        mem_ack_i = 1'b1; mem_data_i = 32'hDEADBEEF;
        tick();
        if ({mem_req_o, mem_we_o, mem_sel_o} !== 6'b1_0_1010) begin
            $display("FAIL load_req_fields: got %b want 101010", {mem_req_o, mem_we_o, mem_sel_o});
        end else n_pass++;
        n_total++;
        if (mem_addr_o !== 32'h100) begin
            $display("FAIL load_addr: got %h want 00000100", mem_addr_o);
        end else n_pass++;
        n_total++;
        if (dc_done_o !== 1'b0) begin
            $display("FAIL load_early_done: got %b want 0", dc_done_o);
        end else n_pass++;
        n_total++;
        tick();
        if ({dc_done_o, mem_req_o} !== 2'b10) begin
            $display("FAIL load_done_c3: got %b want 10", {dc_done_o, mem_req_o});
        end else n_pass++;
        n_total++;
        if (dc_data_o !== 32'hDEADBEEF) begin
            $display("FAIL load_data: got %h want deadbeef", dc_data_o);
        end else n_pass++;
        n_total++;
        dc_ce_i = 1'b0; mem_ack_i = 1'b0;
        tick();
        if ({dc_done_o, mem_req_o} !== 2'b00) begin
            $display("FAIL load_done_pulse: got %b want 00", {dc_done_o, mem_req_o});
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_ic_fill();
        logic [31:0] words [4];
        int done_cnt;
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
        done_cnt = 0;
        ic_read_i = 1'b1; ic_addr_i = 32'h2004; mem_ack_i = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 2; w++) begin
                if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h2000 + 32'(4 * k)}) begin
                    $display("FAIL fill_wait_addr beat %0d: got %b/%h want 1/%h", k, mem_req_o,
                             mem_addr_o, 32'h2000 + 32'(4 * k));
                end else n_pass++;
                n_total++;
                if (ic_done_o) done_cnt++;
                tick();
            end
            mem_ack_i = 1'b1; mem_data_i = words[k];
            if (ic_done_o) done_cnt++;
            tick();
            mem_ack_i = 1'b0; mem_data_i = 32'h0;
        end
        if (ic_done_o) done_cnt++;
        if (ic_data_o !== 128'h00000044_00000033_00000022_00000011) begin
            $display("FAIL fill_line: got %h want 00000044000000330000002200000011", ic_data_o);
        end else n_pass++;
        n_total++;
        if (mem_req_o !== 1'b0) begin
            $display("FAIL fill_req_drop: got %b want 0", mem_req_o);
        end else n_pass++;
        n_total++;
        ic_read_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ic_done_o) done_cnt++;
        end
        if (done_cnt !== 1) begin
            $display("FAIL fill_done_count: got %0d want 1", done_cnt);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_contention();
        ic_read_i = 1'b1; ic_addr_i = 32'h3000;
        dc_ce_i = 1'b1; dc_we_i = 1'b1; dc_addr_i = 32'h40; dc_sel_i = 4'b0011;
        dc_data_i = 32'h55AA; mem_ack_i = 1'b1; mem_data_i = 32'hFFFF0000;
        tick();
        if ({mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o} !==
            {1'b1, 1'b1, 4'b0011, 32'h40, 32'h55AA}) begin
            $display("FAIL cont_dc_first: got %b %b %b %h %h want 1 1 0011 00000040 000055aa",
                     mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o);
        end else n_pass++;
        n_total++;
        tick();
        if ({dc_done_o, ic_done_o, mem_req_o} !== 3'b100) begin
            $display("FAIL cont_dc_done: got %b want 100", {dc_done_o, ic_done_o, mem_req_o});
        end else n_pass++;
        n_total++;
        if (dc_data_o !== 32'hDEADBEEF) begin
            $display("FAIL cont_store_keeps_data: got %h want deadbeef", dc_data_o);
        end else n_pass++;
        n_total++;
        dc_ce_i = 1'b0;
        tick();
        if ({mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, dc_done_o} !==
            {1'b1, 1'b0, 4'hF, 32'h3000, 1'b0}) begin
            $display("FAIL cont_ic_grant: got %b %b %h %h %b want 1 0 f 00003000 0",
                     mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, dc_done_o);
        end else n_pass++;
        n_total++;
        for (int k = 0; k < 4; k++) begin
            if (mem_addr_o !== 32'h3000 + 32'(4 * k)) begin
                $display("FAIL cont_fill_addr beat %0d: got %h want %h", k, mem_addr_o,
                         32'h3000 + 32'(4 * k));
            end else n_pass++;
            n_total++;
            mem_data_i = 32'hC0 + 32'(k);
            tick();
        end
        if ({ic_done_o, dc_done_o} !== 2'b10) begin
            $display("FAIL cont_ic_done: got %b want 10", {ic_done_o, dc_done_o});
        end else n_pass++;
        n_total++;
        if (ic_data_o !== 128'h000000C3_000000C2_000000C1_000000C0) begin
            $display("FAIL cont_line: got %h want 000000c3000000c2000000c1000000c0", ic_data_o);
        end else n_pass++;
        n_total++;
        ic_read_i = 1'b0; mem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_wait_states();
        dc_ce_i = 1'b1; dc_we_i = 1'b1; dc_addr_i = 32'h80; dc_sel_i = 4'b1100;
        dc_data_i = 32'h12345678; mem_ack_i = 1'b0;
        tick();
        // Requester fields change after the grant; the port must not follow them.
        dc_addr_i = 32'hFFFF_FFF0; dc_data_i = 32'h0; dc_sel_i = 4'b0001; dc_we_i = 1'b0;
        for (int w = 0; w < 5; w++) begin
            if ({mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o, dc_done_o} !==
                {1'b1, 1'b1, 4'b1100, 32'h80, 32'h12345678, 1'b0}) begin
                $display("FAIL wait_stable cycle %0d: got %b %b %b %h %h %b", w, mem_req_o,
                         mem_we_o, mem_sel_o, mem_addr_o, mem_data_o, dc_done_o);
            end else n_pass++;
            n_total++;
            tick();
        end
        mem_ack_i = 1'b1;
        tick();
        dc_ce_i = 1'b0; mem_ack_i = 1'b0;
        if ({dc_done_o, mem_req_o} !== 2'b10) begin
            $display("FAIL wait_done: got %b want 10", {dc_done_o, mem_req_o});
        end else n_pass++;
        n_total++;
        tick();
        if (dc_done_o !== 1'b0) begin
            $display("FAIL wait_done_pulse: got %b want 0", dc_done_o);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_reset_mid_fill();
        ic_read_i = 1'b1; ic_addr_i = 32'h4000; mem_ack_i = 1'b1; mem_data_i = 32'hE0;
        tick();
        tick();
        tick();
        if (mem_addr_o !== 32'h4008) begin
            $display("FAIL rmf_pre_addr: got %h want 00004008", mem_addr_o);
        end else n_pass++;
        n_total++;
        rst = 1'b1; ic_read_i = 1'b0;
        tick();
        if ({mem_req_o, ic_done_o} !== 2'b00) begin
            $display("FAIL rmf_req_drop: got %b want 00", {mem_req_o, ic_done_o});
        end else n_pass++;
        n_total++;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if ({mem_req_o, ic_done_o, dc_done_o} !== 3'b000) begin
                $display("FAIL rmf_stray_ack: got %b want 000", {mem_req_o, ic_done_o, dc_done_o});
            end else n_pass++;
            n_total++;
        end
        ic_read_i = 1'b1; ic_addr_i = 32'h5008;
        tick();
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h5000}) begin
            $display("FAIL rmf_refill_start: got %b/%h want 1/00005000", mem_req_o, mem_addr_o);
        end else n_pass++;
        n_total++;
        for (int k = 0; k < 4; k++) begin
            mem_data_i = 32'hB0 + 32'(k);
            tick();
        end
        if ({ic_done_o, ic_data_o} !== {1'b1, 128'h000000B3_000000B2_000000B1_000000B0}) begin
            $display("FAIL rmf_refill_line: got %b/%h want 1/000000b3000000b2000000b1000000b0",
                     ic_done_o, ic_data_o);
        end else n_pass++;
        n_total++;
        ic_read_i = 1'b0; mem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_dropped_request();
        dc_ce_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 32'h200; dc_sel_i = 4'hF;
        mem_data_i = 32'h0BADF00D; mem_ack_i = 1'b0;
        tick();
        dc_ce_i = 1'b0;
        tick();
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h200}) begin
            $display("FAIL drop_still_issued: got %b/%h want 1/00000200", mem_req_o, mem_addr_o);
        end else n_pass++;
        n_total++;
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        if ({dc_done_o, dc_data_o} !== {1'b1, 32'h0BADF00D}) begin
            $display("FAIL drop_done: got %b/%h want 1/0badf00d", dc_done_o, dc_data_o);
        end else n_pass++;
        n_total++;
        tick();
        if ({dc_done_o, mem_req_o} !== 2'b00) begin
            $display("FAIL drop_single_pulse: got %b want 00", {dc_done_o, mem_req_o});
        end else n_pass++;
        n_total++;
    endtask

    initial begin
        test_reset();
        test_dc_load();
        test_ic_fill();
        test_contention();
        test_wait_states();
        test_reset_mid_fill();
        test_dropped_request();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
